fp_add_arbiter: RTL and testbench
=================================

# fp_add_arbiter

Round-robin arbiter and sequencer that shares one `fp_adder` instance between `NUM_REQ` independent requesters in the execution stage. It accepts one operand pair at a time and issues it to the adder with a single-cycle `valid` pulse. It waits for `done`, or gives up after a timeout, and routes the result back to the requester that was granted. It is the only block allowed to drive the adder's `op1`/`op2`/`valid` inputs.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 64: maximum cycles to wait for `fpu_done` after issue, 1..255.

Ports:
- `clk`  in  1: single clock, all logic on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: bit i is high while requester i has an operand pair pending.
- `req_op1`  in  32*NUM_REQ: IEEE-754 single-precision operand A, requester i in bits [32i+31:32i].
- `req_op2`  in  32*NUM_REQ: operand B, same packing.
- `req_ready`  out  NUM_REQ: one-hot grant; transfer occurs when `req_valid[i] & req_ready[i]`.
- `resp_valid`  out  NUM_REQ: one-hot, one-cycle response pulse to the owning requester.
- `resp_result`  out  32: result, valid only while any `resp_valid` bit is high.
- `resp_error`  out  1: high together with `resp_valid` when the response is due to timeout.
- `busy`  out  1: high in every state except IDLE.
- `fpu_op1`, `fpu_op2`  out  32: operands to the adder, registered and held from accept until return to IDLE.
- `fpu_valid`  out  1: one-cycle issue pulse to the adder.
- `fpu_result`  in  32: adder result.
- `fpu_done`  in  1: adder completion.

## Operation
- Three states:
  - IDLE: `req_ready` = one-hot winner among `req_valid`, chosen combinationally. `req_ready` is all-zero if no request is pending. On a transfer, latch the operands and the grant index, then go to ISSUE.
  - ISSUE: `fpu_valid` = 1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
  - WAIT: increment the counter each cycle.
    - If `fpu_done` is high: register `resp_result` ← `fpu_result` and `resp_error` ← 0, pulse `resp_valid[grant]`, go to IDLE.
    - Else if the counter reaches `TIMEOUT`: register `resp_result` ← 32'h7FC00000 (quiet NaN) and `resp_error` ← 1, pulse `resp_valid[grant]`, go to IDLE.
    - `fpu_done` wins if it arrives on the same cycle as timeout expiry.
- Round-robin arbitration:
  - The search starts at the pointer and wraps modulo NUM_REQ.
  - After each accept, pointer ← grant + 1, wrapping from NUM_REQ-1 to 0.
  - The pointer resets to 0, so requester 0 has priority first.
  - A requester that keeps `req_valid` high is served at most once per round when others are also requesting.
- `fpu_done` outside WAIT is ignored and has no effect on state.
- Operands arriving while not in IDLE are not accepted; `req_ready` is 0 in ISSUE and WAIT.
- Requesters must hold `req_valid` and their operands stable until `req_ready`; deasserting earlier is legal and simply withdraws the request.

## Timing
- Reset values: state IDLE, pointer 0; `req_ready` 0 (no requests), `resp_valid` 0, `resp_result` 0, `resp_error` 0, `busy` 0, `fpu_valid` 0, `fpu_op1`/`fpu_op2` 0.
- Accept at cycle T. `fpu_valid` is high at T+1. WAIT begins at T+2.
- If `fpu_done` is sampled high at cycle D ≥ T+2, `resp_valid` is high at D+1.
- In the `resp_valid` cycle the block is already in IDLE and may accept the next request that same cycle, giving back-to-back throughput of one op per (adder latency + 2) cycles.
- Timeout: with no `fpu_done`, `resp_valid`/`resp_error` are high at cycle T+2+TIMEOUT.
- Reset asserted mid-operation: all outputs and state return to reset values immediately (asynchronous). The in-flight op is discarded with no response. A late `fpu_done` after release is ignored because the state is IDLE.

## Test plan
- Single request: `req_valid[0]`, op1 = 40200000, op2 = 40400000 → `req_ready[0]` in the same cycle, `fpu_valid` pulse one cycle later, then `resp_valid[0]` with `resp_result` = 40B00000 and `resp_error` = 0.
- All four requesters valid simultaneously from reset, with ops (2.5,−3.0), (−2.5,−3.0), (2.5,+inf), (2.5,3.0) → grants in order 0,1,2,3. Results BF000000, C0B00000, 7F800000, 40B00000, each on the matching `resp_valid` bit.
- Fairness: requesters 1 and 3 held valid continuously → grants alternate 1,3,1,3 and requester 1 is never granted twice in a row.
- Timeout: stub adder that never asserts `fpu_done`, TIMEOUT = 8 → `resp_valid` at accept + 10 cycles, `resp_result` = 7FC00000, `resp_error` = 1, `busy` low afterwards.
- Spurious `fpu_done` pulses in IDLE and ISSUE → no `resp_valid` and no state change. `fpu_done` coinciding with timeout expiry → normal result with `resp_error` = 0.
- Reset pulse during WAIT, then `fpu_done` after release → no response. The next request is granted starting from requester 0.

Source files
------------

// File: rtl/fp_add_arbiter_if.sv
// Bus bundle between the execution-stage requesters, the shared fp_adder and fp_add_arbiter.
// The arbiter connects through the slave modport; the requester/adder side uses master.
interface fp_add_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_op1;
  logic [32*NUM_REQ-1:0] req_op2;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_result;
  logic                  resp_error;
  logic                  busy;
  logic [31:0]           fpu_op1;
  logic [31:0]           fpu_op2;
  logic                  fpu_valid;
  logic [31:0]           fpu_result;
  logic                  fpu_done;

  modport slave (
    input  req_valid, req_op1, req_op2, fpu_result, fpu_done,
    output req_ready, resp_valid, resp_result, resp_error, busy,
           fpu_op1, fpu_op2, fpu_valid
  );

  modport master (
    output req_valid, req_op1, req_op2, fpu_result, fpu_done,
    input  req_ready, resp_valid, resp_result, resp_error, busy,
           fpu_op1, fpu_op2, fpu_valid
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin sequencer sharing one fp_adder among NUM_REQ requesters: accept one
// operand pair, pulse the adder, wait for done or timeout, route the result back.
module fp_add_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  fp_add_arbiter_if.slave  bus
);
  localparam int unsigned   IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW:0]   NREQ = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
  localparam logic [7:0]    TO8  = 8'(TIMEOUT);
  localparam logic [31:0]   QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [31:0]        op1_q, op1_d;
  logic [31:0]        op2_q, op2_d;
  logic [31:0]        res_q, res_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] rv_q, rv_d;

  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [IW:0]        sum;
  logic [31:0]        sel_op1, sel_op2;
  logic [NUM_REQ-1:0] grant_oh;

  // Search from the pointer upward, wrapping modulo NUM_REQ; first pending requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= NREQ) sum = sum - NREQ;
      if (!win_found && bus.req_valid[sum[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_op1  = '0;
    sel_op2  = '0;
    grant_oh = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IW'(k)) begin
        sel_op1 = bus.req_op1[32*k +: 32];
        sel_op2 = bus.req_op2[32*k +: 32];
      end
    end
    grant_oh[win_idx] = win_found;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    err_d   = err_q;
    rv_d    = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = ISSUE;
          grant_d = win_idx;
          ptr_d   = (win_idx == LAST) ? '0 : win_idx + 1'b1;
          op1_d   = sel_op1;
          op2_d   = sel_op2;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // done takes precedence over a timeout expiring in the same cycle
        if (bus.fpu_done) begin
          res_d          = bus.fpu_result;
          err_d          = 1'b0;
          rv_d[grant_q]  = 1'b1;
          state_d        = IDLE;
        end else if (cnt_q + 8'd1 == TO8) begin
          res_d          = QNAN;
          err_d          = 1'b1;
          rv_d[grant_q]  = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      rv_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE) ? grant_oh : '0;
  assign bus.resp_valid  = rv_q;
  assign bus.resp_result = res_q;
  assign bus.resp_error  = err_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.fpu_valid   = (state_q == ISSUE);
  assign bus.fpu_op1     = op1_q;
  assign bus.fpu_op2     = op2_q;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter: requesters and a stub adder with programmable
// latency; expected grants, results, errors and response cycles come from a reference model.
module tb_fp_add_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_add_arbiter_if #(.NUM_REQ(N)) bus();

  fp_add_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    int          acc;
    int          dly;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e_m;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          ptr_m = 0;
  int          last_g = -1;
  logic        fair_phase = 1'b0;
  logic [N-1:0] xfer_mask = '0;
  logic [N-1:0] last_xfer = '0;
  int          cur_lat = 3;
  int          issue_lat = 0;
  logic [N-1:0] pend   = '0;
  logic [N-1:0] refill = '0;
  logic [31:0] a_in [N];
  logic [31:0] b_in [N];
  int          stub_cnt = 0;
  logic        stub_done = 1'b0;
  logic [31:0] stub_res = '0;
  logic [31:0] sa = '0;
  logic [31:0] sb = '0;
  logic        spur = 1'b0;

  assign bus.fpu_done   = stub_done | spur;
  assign bus.fpu_result = stub_res;

  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Adder behaviour: IEEE sums for the directed vectors, a fixed mixing function otherwise.
  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
    case ({a, b})
      64'h40200000_40400000: return 32'h40B00000;
      64'h40200000_C0400000: return 32'hBF000000;
      64'hC0200000_C0400000: return 32'hC0B00000;
      64'h40200000_7F800000: return 32'h7F800000;
      default:               return a ^ {b[15:0], b[31:16]};
    endcase
  endfunction

  function automatic int pick(logic [N-1:0] v, int p);
    int order[$];
    for (int k = 0; k < N; k++) order.push_back((p + k) % N);
    foreach (order[k]) if (v[order[k]]) return order[k];
    return -1;
  endfunction

  // Stub adder: loads latency on the issue pulse, raises done for one cycle when it expires.
  always @(negedge clk) begin
    if (bus.fpu_valid === 1'b1 && issue_lat != 0) begin
      stub_cnt = issue_lat;
      sa = bus.fpu_op1;
      sb = bus.fpu_op2;
    end
  end

  always begin
    @(posedge clk);
    #1;
    stub_done = 1'b0;
    stub_res  = $urandom;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        stub_done = 1'b1;
        stub_res  = fadd(sa, sb);
      end
    end
  end

  // Monitor: pops the scoreboard on responses and predicts grant/issue/busy every cycle.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_rdy;
    logic exp_fv;
    if (!rst_n) begin
      sbq.delete();
      ptr_m     = 0;
      last_g    = -1;
      xfer_mask = '0;
      chk("rst_busy",       bus.busy,        0);
      chk("rst_resp_valid", bus.resp_valid,  0);
      chk("rst_resp_result",bus.resp_result, 0);
      chk("rst_resp_error", bus.resp_error,  0);
      chk("rst_fpu_valid",  bus.fpu_valid,   0);
      chk("rst_fpu_op1",    bus.fpu_op1,     0);
      chk("rst_fpu_op2",    bus.fpu_op2,     0);
      chk("rst_req_ready",  bus.req_ready,   0);
    end else begin
      if (bus.resp_valid !== '0) begin
        if (sbq.size() == 0) begin
          chk("spurious_resp", bus.resp_valid, 0);
        end else begin
          e_m = sbq.pop_front();
          chk("resp_valid",  bus.resp_valid,  32'(1) << e_m.idx);
          chk("resp_result", bus.resp_result, e_m.res);
          chk("resp_error",  bus.resp_error,  e_m.err);
          chk("resp_delay",  cyc - e_m.acc,   e_m.dly);
        end
      end else if (sbq.size() > 0 && cyc - sbq[0].acc > sbq[0].dly) begin
        chk("resp_missing", 0, 1);
        void'(sbq.pop_front());
      end

      exp_fv = (sbq.size() > 0) && (cyc == sbq[0].acc + 1);
      chk("fpu_valid", bus.fpu_valid, exp_fv);
      if (exp_fv) begin
        chk("fpu_op1", bus.fpu_op1, sbq[0].a);
        chk("fpu_op2", bus.fpu_op2, sbq[0].b);
      end
      chk("busy", bus.busy, sbq.size() > 0);

      exp_rdy = '0;
      g = -1;
      if (sbq.size() == 0) g = pick(bus.req_valid, ptr_m);
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", bus.req_ready, exp_rdy);
      xfer_mask = bus.req_valid & bus.req_ready;

      if (g >= 0) begin
        if (fair_phase && last_g >= 0 && $countones(bus.req_valid) >= 2)
          chk("fair_repeat", g == last_g, 0);
        last_g  = g;
        e_m.idx = g;
        e_m.a   = a_in[g];
        e_m.b   = b_in[g];
        e_m.err = (cur_lat == 0) || (cur_lat > TO);
        e_m.res = e_m.err ? QNAN : fadd(a_in[g], b_in[g]);
        e_m.acc = cyc;
        e_m.dly = 2 + (e_m.err ? TO : cur_lat);
        sbq.push_back(e_m);
        issue_lat = cur_lat;
        ptr_m = (g + 1) % N;
      end
    end
  end

  task automatic drive();
    bus.req_valid = pend;
    for (int i = 0; i < N; i++) begin
      bus.req_op1[32*i +: 32] = a_in[i];
      bus.req_op2[32*i +: 32] = b_in[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    last_xfer = xfer_mask;
    for (int i = 0; i < N; i++) begin
      if (xfer_mask[i]) begin
        if (refill[i]) begin
          a_in[i] = $urandom;
          b_in[i] = $urandom;
        end else begin
          pend[i] = 1'b0;
        end
      end
    end
    drive();
  endtask

  task automatic wait_quiet(input int max);
    int n = 0;
    while ((pend != 0 || sbq.size() != 0 || stub_cnt != 0) && n < max) begin
      step();
      n++;
    end
    if (n >= max) chk("wait_quiet_timeout", n, 0);
  endtask

  task automatic wait_accept(input int max);
    int n = 0;
    do begin
      step();
      n++;
    end while (last_xfer == '0 && n < max);
    if (last_xfer == '0) chk("wait_accept_timeout", n, 0);
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    a_in[i] = a;
    b_in[i] = b;
    pend[i] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
    end
    drive();
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // single request from requester 0
    cur_lat = 3;
    set_op(0, 32'h40200000, 32'h40400000);
    drive();
    wait_quiet(100);

    // all four at once straight out of reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    cur_lat = 2;
    set_op(0, 32'h40200000, 32'hC0400000);
    set_op(1, 32'hC0200000, 32'hC0400000);
    set_op(2, 32'h40200000, 32'h7F800000);
    set_op(3, 32'h40200000, 32'h40400000);
    drive();
    wait_quiet(200);

    // fairness: requesters 1 and 3 held continuously
    fair_phase = 1'b1;
    last_g     = -1;
    cur_lat    = 1;
    refill     = 4'b1010;
    set_op(1, $urandom, $urandom);
    set_op(3, $urandom, $urandom);
    drive();
    repeat (40) step();
    refill = '0;
    wait_quiet(100);
    fair_phase = 1'b0;

    // timeout with an adder that never answers
    cur_lat = 0;
    set_op(2, $urandom, $urandom);
    drive();
    wait_quiet(100);

    // done arriving exactly on the timeout cycle
    cur_lat = TO;
    set_op(1, $urandom, $urandom);
    drive();
    wait_quiet(100);

    // spurious done while idle
    spur = 1'b1;
    step();
    step();
    spur = 1'b0;
    repeat (3) step();

    // spurious done during the issue cycle
    cur_lat = 4;
    set_op(3, $urandom, $urandom);
    drive();
    wait_accept(50);
    spur = 1'b1;
    step();
    spur = 1'b0;
    wait_quiet(100);

    // reset while waiting; the late done must be ignored and arbitration restarts at 0
    cur_lat = 6;
    set_op(2, $urandom, $urandom);
    drive();
    wait_accept(50);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (6) step();
    cur_lat = 3;
    set_op(3, $urandom, $urandom);
    set_op(0, $urandom, $urandom);
    drive();
    wait_quiet(100);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      cur_lat = $urandom_range(0, TO);
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0) set_op(i, $urandom, $urandom);
      drive();
      step();
    end
    wait_quiet(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
